// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code register with one-deep undo shadow and Y86-64 cnd evaluation.
// Optional macro CC_BYPASS_EN forwards incoming cf to cnd/cond_err on an accepted update cycle.
module cc_cond_unit #(
    parameter int              CC_W     = 3,
    parameter logic [CC_W-1:0] CC_RESET = 3'b100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CC_W-1:0] cf,
    input  logic            set_cc,
    input  logic            suppress,
    input  logic            stall,
    input  logic            cc_restore,
    input  logic [3:0]      ifun,
    output logic [CC_W-1:0] cc,
    output logic            cnd,
    output logic            cond_err,
    output logic            armed,
    output logic            restore_err
);

    logic [CC_W-1:0] cc_r;
    logic [CC_W-1:0] shadow_r;
    logic            armed_r;
    logic            restore_err_r;
    logic [CC_W-1:0] eval_flags_s;
    logic [1:0]      eval_s;

    // Returns {cond_err, cnd} for flags {ZF, SF, OF} and a jXX/cmovXX function code.
    function automatic logic [1:0] eval_cond(input logic [2:0] flags, input logic [3:0] fn);
        logic zf;
        logic x;
        zf = flags[2];
        x  = flags[1] ^ flags[0];
        case (fn)
            4'd0:    eval_cond = {1'b0, 1'b1};
            4'd1:    eval_cond = {1'b0, x | zf};
            4'd2:    eval_cond = {1'b0, x};
            4'd3:    eval_cond = {1'b0, zf};
            4'd4:    eval_cond = {1'b0, ~zf};
            4'd5:    eval_cond = {1'b0, ~x};
            4'd6:    eval_cond = {1'b0, ~x & ~zf};
            default: eval_cond = {1'b1, 1'b0};
        endcase
    endfunction

    // CC register, shadow copy and restore window; stall beats restore beats update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_r          <= CC_RESET;
            shadow_r      <= CC_RESET;
            armed_r       <= 1'b0;
            restore_err_r <= 1'b0;
        end else if (stall) begin
            restore_err_r <= 1'b0;
        end else if (cc_restore) begin
            if (armed_r) begin
                cc_r          <= shadow_r;
                armed_r       <= 1'b0;
                restore_err_r <= 1'b0;
            end else begin
                restore_err_r <= 1'b1;
            end
        end else if (set_cc && !suppress) begin
            shadow_r      <= cc_r;
            cc_r          <= cf;
            armed_r       <= 1'b1;
            restore_err_r <= 1'b0;
        end else begin
            armed_r       <= 1'b0;
            restore_err_r <= 1'b0;
        end
    end

    // Select which flags feed the condition evaluator.
    always_comb begin
        eval_flags_s = cc_r;
`ifdef CC_BYPASS_EN
        if (set_cc && !suppress && !stall && !cc_restore) begin
            eval_flags_s = cf;
        end else begin
            eval_flags_s = cc_r;
        end
`endif
        eval_s = eval_cond(eval_flags_s, ifun);
    end

    assign cc          = cc_r;
    assign armed       = armed_r;
    assign restore_err = restore_err_r;
    assign cnd         = eval_s[0];
    assign cond_err    = eval_s[1];

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed self-checking bench for cc_cond_unit; inputs change 1ns after each rising edge.
module tb_cc_cond_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] cf;
    logic       set_cc;
    logic       suppress;
    logic       stall;
    logic       cc_restore;
    logic [3:0] ifun;
    logic [2:0] cc;
    logic       cnd;
    logic       cond_err;
    logic       armed;
    logic       restore_err;

    int tests_run    = 0;
    int tests_failed = 0;

    cc_cond_unit dut (
        .clk(clk), .rst_n(rst_n), .cf(cf), .set_cc(set_cc), .suppress(suppress),
        .stall(stall), .cc_restore(cc_restore), .ifun(ifun), .cc(cc), .cnd(cnd),
        .cond_err(cond_err), .armed(armed), .restore_err(restore_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        set_cc = 1'b0; suppress = 1'b0; stall = 1'b0; cc_restore = 1'b0; cf = 3'b000;
    endtask

    task automatic test_reset();
        idle_inputs();
        ifun = 4'd3;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (cc !== 3'b100) begin tests_failed++; $display("FAIL reset_cc got %b want 100", cc); end
        tests_run++;
        if (armed !== 1'b0 || restore_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags got armed=%b err=%b want 0 0", armed, restore_err);
        end
        tests_run++;
        if (cnd !== 1'b1) begin tests_failed++; $display("FAIL reset_cnd_e got %b want 1", cnd); end
        ifun = 4'd4; #1;
        tests_run++;
        if (cnd !== 1'b0) begin tests_failed++; $display("FAIL reset_cnd_ne got %b want 0", cnd); end
        step();
        rst_n = 1'b1;
        step();
        // Mid-cycle reset after an update must clear state immediately.
        set_cc = 1'b1; cf = 3'b011;
        step();
        set_cc = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (cc !== 3'b100 || armed !== 1'b0) begin
            tests_failed++; $display("FAIL reset_midcycle got cc=%b armed=%b want 100 0", cc, armed);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_update();
        set_cc = 1'b1; cf = 3'b000;
        step();
        set_cc = 1'b0;
        tests_run++;
        if (cc !== 3'b000 || armed !== 1'b1) begin
            tests_failed++; $display("FAIL update_cc got cc=%b armed=%b want 000 1", cc, armed);
        end
        ifun = 4'd6; #1;
        tests_run++;
        if (cnd !== 1'b1) begin tests_failed++; $display("FAIL update_cnd_g got %b want 1", cnd); end
        ifun = 4'd2; #1;
        tests_run++;
        if (cnd !== 1'b0) begin tests_failed++; $display("FAIL update_cnd_l got %b want 0", cnd); end
        step();
        tests_run++;
        if (armed !== 1'b0 || cc !== 3'b000) begin
            tests_failed++; $display("FAIL update_window got cc=%b armed=%b want 000 0", cc, armed);
        end
    endtask

    task automatic test_overflow();
        set_cc = 1'b1; cf = 3'b011;
        step();
        set_cc = 1'b0;
        tests_run++;
        if (cc !== 3'b011) begin tests_failed++; $display("FAIL ovf_cc got %b want 011", cc); end
        ifun = 4'd2; #1;
        tests_run++;
        if (cnd !== 1'b0) begin tests_failed++; $display("FAIL ovf_cnd_l got %b want 0", cnd); end
        ifun = 4'd5; #1;
        tests_run++;
        if (cnd !== 1'b1) begin tests_failed++; $display("FAIL ovf_cnd_ge got %b want 1", cnd); end
        ifun = 4'd1; #1;
        tests_run++;
        if (cnd !== 1'b0) begin tests_failed++; $display("FAIL ovf_cnd_le got %b want 0", cnd); end
    endtask

    task automatic test_restore();
        set_cc = 1'b1; cf = 3'b000;
        step();
        cf = 3'b010;
        step();
        set_cc = 1'b1; cf = 3'b100; cc_restore = 1'b1;
        step();
        tests_run++;
        if (cc !== 3'b000 || armed !== 1'b0 || restore_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL restore_ok got cc=%b armed=%b err=%b want 000 0 0", cc, armed, restore_err);
        end
        set_cc = 1'b0;
        step();
        tests_run++;
        if (cc !== 3'b000 || restore_err !== 1'b1) begin
            tests_failed++; $display("FAIL restore_unarmed got cc=%b err=%b want 000 1", cc, restore_err);
        end
        cc_restore = 1'b0;
        step();
        tests_run++;
        if (restore_err !== 1'b0) begin tests_failed++; $display("FAIL restore_err_pulse got %b want 0", restore_err); end
    endtask

    task automatic test_back_to_back();
        set_cc = 1'b1; cf = 3'b010;
        step();
        cf = 3'b001;
        step();
        set_cc = 1'b0; cc_restore = 1'b1;
        step();
        cc_restore = 1'b0;
        tests_run++;
        if (cc !== 3'b010) begin tests_failed++; $display("FAIL b2b_restore got %b want 010", cc); end
        // Stall keeps the restore window open.
        set_cc = 1'b1; cf = 3'b110;
        step();
        set_cc = 1'b0; stall = 1'b1;
        step();
        stall = 1'b0; cc_restore = 1'b1;
        step();
        cc_restore = 1'b0;
        tests_run++;
        if (cc !== 3'b010 || restore_err !== 1'b0) begin
            tests_failed++; $display("FAIL stall_window got cc=%b err=%b want 010 0", cc, restore_err);
        end
        // Expired window: update, idle, then restore fails.
        set_cc = 1'b1; cf = 3'b101;
        step();
        set_cc = 1'b0;
        step();
        cc_restore = 1'b1;
        step();
        cc_restore = 1'b0;
        tests_run++;
        if (cc !== 3'b101 || restore_err !== 1'b1) begin
            tests_failed++; $display("FAIL expired_window got cc=%b err=%b want 101 1", cc, restore_err);
        end
        step();
    endtask

    task automatic test_stall_suppress();
        set_cc = 1'b1; cf = 3'b001;
        step();
        stall = 1'b1; cf = 3'b111;
        step();
        tests_run++;
        if (cc !== 3'b001 || armed !== 1'b1) begin
            tests_failed++; $display("FAIL stall_hold got cc=%b armed=%b want 001 1", cc, armed);
        end
        stall = 1'b0; suppress = 1'b1; cf = 3'b100;
        step();
        tests_run++;
        if (cc !== 3'b001 || armed !== 1'b0) begin
            tests_failed++; $display("FAIL suppress got cc=%b armed=%b want 001 0", cc, armed);
        end
        suppress = 1'b0; set_cc = 1'b0; cc_restore = 1'b1;
        step();
        stall = 1'b1;
        step();
        tests_run++;
        if (restore_err !== 1'b0 || cc !== 3'b001) begin
            tests_failed++; $display("FAIL stall_clears_err got err=%b cc=%b want 0 001", restore_err, cc);
        end
        idle_inputs();
        ifun = 4'd9; #1;
        tests_run++;
        if (cnd !== 1'b0 || cond_err !== 1'b1) begin
            tests_failed++; $display("FAIL bad_ifun9 got cnd=%b err=%b want 0 1", cnd, cond_err);
        end
        ifun = 4'd15; #1;
        tests_run++;
        if (cnd !== 1'b0 || cond_err !== 1'b1) begin
            tests_failed++; $display("FAIL bad_ifun15 got cnd=%b err=%b want 0 1", cnd, cond_err);
        end
        ifun = 4'd0; #1;
        tests_run++;
        if (cnd !== 1'b1 || cond_err !== 1'b0) begin
            tests_failed++; $display("FAIL ifun_always got cnd=%b err=%b want 1 0", cnd, cond_err);
        end
    endtask

    task automatic test_bypass();
        logic exp_cnd;
`ifdef CC_BYPASS_EN
        exp_cnd = 1'b1;
`else
        exp_cnd = 1'b0;
`endif
        set_cc = 1'b1; cf = 3'b000;
        step();
        cf = 3'b100; ifun = 4'd3; #1;
        tests_run++;
        if (cnd !== exp_cnd) begin tests_failed++; $display("FAIL bypass_cnd got %b want %b", cnd, exp_cnd); end
        step();
        set_cc = 1'b0;
        tests_run++;
        if (cc !== 3'b100 || cnd !== 1'b1) begin
            tests_failed++; $display("FAIL bypass_after got cc=%b cnd=%b want 100 1", cc, cnd);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        ifun = 4'd0;
        rst_n = 1'b1;
        #3;
        test_reset();
        test_update();
        test_overflow();
        test_restore();
        test_back_to_back();
        test_stall_suppress();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
